interrupt_controller: RTL and testbench



---
 rtl/interrupt_controller_pkg.sv | 32 +++
 rtl/interrupt_controller_if.sv | 47 ++++
 rtl/intif_prio_enc.sv | 34 +++
 rtl/interrupt_controller.sv | 148 ++++++++++++++
 tb/tb_interrupt_controller.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/interrupt_controller_pkg.sv
// +----------------------------------------------------------------------------+
// | interrupt_controller_pkg : shared types and constants for the interrupt    |
// | front end.                                     Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

package interrupt_controller_pkg;

  localparam int REG_DATA_WIDTH = `REG_DATA_WIDTH;
  localparam int MCAUSE_IRQ_BIT = REG_DATA_WIDTH - 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } intif_state_t;

  typedef enum logic [7:0] {
    IRQ_M_SOFT  = 8'd3,
    IRQ_M_TIMER = 8'd7,
    IRQ_M_EXT   = 8'd11
  } riscv_interrupt_t;

  // Slice i belongs to source i: src0=external, src1=software, src2=timer.
  localparam logic [23:0] DEFAULT_CAUSE_CODE = {IRQ_M_TIMER, IRQ_M_SOFT, IRQ_M_EXT};

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_if.sv
// +----------------------------------------------------------------------------+
// | interrupt_controller_if : source, csrfile and commit-side signals of the   |
// | interrupt front end.                           Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface interrupt_controller_if #(
  parameter int NUM_SRC = 3
) ();
  import interrupt_controller_pkg::*;

  logic [NUM_SRC-1:0]        src_intif_req;
  logic [NUM_SRC-1:0]        intif_src_ack;
  logic [NUM_SRC-1:0]        csrf_intif_mie;
  logic                      csrf_intif_mstatus_mie;
  logic [NUM_SRC-1:0]        intif_csrf_pending;
  logic                      intif_commit_has_interrupt;
  logic [REG_DATA_WIDTH-1:0] intif_commit_mcause_data;
  logic [NUM_SRC-1:0]        intif_commit_claim;
  logic                      commit_intif_take;
  logic [NUM_SRC-1:0]        commit_intif_take_id;
  logic                      commit_intif_complete;
  logic                      intif_take_err;
  logic                      intif_in_service;
  logic [NUM_SRC-1:0]        intif_in_service_id;

  // Controller view.
  modport master (
    input  src_intif_req, csrf_intif_mie, csrf_intif_mstatus_mie,
           commit_intif_take, commit_intif_take_id, commit_intif_complete,
    output intif_src_ack, intif_csrf_pending, intif_commit_has_interrupt,
           intif_commit_mcause_data, intif_commit_claim, intif_take_err,
           intif_in_service, intif_in_service_id
  );

  // Sources / csrfile / commit view.
  modport slave (
    output src_intif_req, csrf_intif_mie, csrf_intif_mstatus_mie,
           commit_intif_take, commit_intif_take_id, commit_intif_complete,
    input  intif_src_ack, intif_csrf_pending, intif_commit_has_interrupt,
           intif_commit_mcause_data, intif_commit_claim, intif_take_err,
           intif_in_service, intif_in_service_id
  );

endinterface

`default_nettype wire

// File: rtl/intif_prio_enc.sv
// +----------------------------------------------------------------------------+
// | intif_prio_enc : lowest-index-wins one-hot priority encoder with binary    |
// | index output.                                  Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module intif_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

  assign valid = |req;

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// +----------------------------------------------------------------------------+
// | interrupt_controller : level/edge pending latch, fixed-priority selection  |
// | and take/complete tracking. Optional INTIF_REQ_SYNC_EN adds a 2-flop       |
// | request synchroniser.                          Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int                     NUM_SRC    = 3,
  parameter logic [NUM_SRC-1:0]     EDGE_MASK  = '0,
  parameter logic [NUM_SRC*8-1:0]   CAUSE_CODE = DEFAULT_CAUSE_CODE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  interrupt_controller_if.master intif
);

  localparam int         IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [NUM_SRC-1:0]        req_s;
  logic [NUM_SRC-1:0]        req_prev_q, req_prev_d;
  logic [NUM_SRC-1:0]        pending_q, pending_d;
  logic [0:0]                state_q, state_d;
  logic [NUM_SRC-1:0]        in_service_id_q, in_service_id_d;
  logic [NUM_SRC-1:0]        ack_q, ack_d;
  logic                      take_err_q, take_err_d;

  logic [NUM_SRC-1:0]        eligible;
  logic [NUM_SRC-1:0]        claim;
  logic [IDX_W-1:0]          sel_idx;
  logic                      sel_valid;
  logic [REG_DATA_WIDTH-1:0] mcause;
  logic                      take_onehot;
  logic                      take_accept;
  logic [NUM_SRC-1:0]        take_clr;

`ifdef INTIF_REQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= intif.src_intif_req;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = intif.src_intif_req;
`endif

  // Nothing is claimable while an interrupt is in service.
  assign eligible = pending_q
                  & intif.csrf_intif_mie
                  & {NUM_SRC{intif.csrf_intif_mstatus_mie}}
                  & {NUM_SRC{state_q == ST_IDLE}};

  intif_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req    (eligible),
    .onehot (claim),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  always_comb begin
    mcause = '0;
    if (sel_valid) begin
      mcause[MCAUSE_IRQ_BIT] = 1'b1;
      mcause[7:0]            = CAUSE_CODE[int'(sel_idx)*8 +: 8];
    end
  end

  // A take must name exactly the source being claimed right now.
  assign take_onehot = (intif.commit_intif_take_id != '0) &&
                       ((intif.commit_intif_take_id &
                         (intif.commit_intif_take_id - NUM_SRC'(1))) == '0);
  assign take_accept = intif.commit_intif_take && take_onehot &&
                       (intif.commit_intif_take_id == claim);
  assign take_clr    = take_accept ? intif.commit_intif_take_id : '0;

  always_comb begin
    req_prev_d = req_s;
    pending_d  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        // New edge beats a same-cycle clear so the event is not lost.
        pending_d[i] = (req_s[i] & ~req_prev_q[i]) | (pending_q[i] & ~take_clr[i]);
      end else begin
        pending_d[i] = req_s[i];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    in_service_id_d = in_service_id_q;
    if ((state_q == ST_BUSY) && intif.commit_intif_complete) begin
      state_d         = ST_IDLE;
      in_service_id_d = '0;
    end
    if (take_accept) begin
      state_d         = ST_BUSY;
      in_service_id_d = intif.commit_intif_take_id;
    end
    ack_d      = take_clr;
    take_err_d = intif.commit_intif_take && !take_accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev_q      <= '0;
      pending_q       <= '0;
      state_q         <= ST_IDLE;
      in_service_id_q <= '0;
      ack_q           <= '0;
      take_err_q      <= 1'b0;
    end else begin
      req_prev_q      <= req_prev_d;
      pending_q       <= pending_d;
      state_q         <= state_d;
      in_service_id_q <= in_service_id_d;
      ack_q           <= ack_d;
      take_err_q      <= take_err_d;
    end
  end

  assign intif.intif_src_ack              = ack_q;
  assign intif.intif_csrf_pending         = pending_q;
  assign intif.intif_commit_has_interrupt = sel_valid;
  assign intif.intif_commit_mcause_data   = mcause;
  assign intif.intif_commit_claim         = claim;
  assign intif.intif_take_err             = take_err_q;
  assign intif.intif_in_service           = (state_q == ST_BUSY);
  assign intif.intif_in_service_id        = in_service_id_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// +----------------------------------------------------------------------------+
// | tb_interrupt_controller : directed scoreboard bench for the interrupt      |
// | front end (default build, src2 edge-triggered). Revision: 1.0              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_interrupt_controller;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_SRC(3)) ifc ();

  interrupt_controller #(
    .NUM_SRC    (3),
    .EDGE_MASK  (3'b100),
    .CAUSE_CODE (24'h07_03_0B)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .intif (ifc.master)
  );

  typedef struct packed {
    logic [2:0] ack;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [2:0] ack, input logic err);
    exp_t e;
    e.ack = ack;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: every ack or take_err pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (ifc.intif_src_ack != 3'b000 || ifc.intif_take_err)) begin
      exp_t e;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got ack=%b err=%b, expected no pulse",
                 ifc.intif_src_ack, ifc.intif_take_err);
      end else begin
        e = exp_q.pop_front();
        if (ifc.intif_src_ack !== e.ack || ifc.intif_take_err !== e.err) begin
          n_fail++;
          $display("FAIL pulse: got ack=%b err=%b, expected ack=%b err=%b",
                   ifc.intif_src_ack, ifc.intif_take_err, e.ack, e.err);
        end
      end
    end
  end

  initial begin
    rst_n                      = 1'b0;
    ifc.src_intif_req          = '0;
    ifc.csrf_intif_mie         = '0;
    ifc.csrf_intif_mstatus_mie = 1'b0;
    ifc.commit_intif_take      = 1'b0;
    ifc.commit_intif_take_id   = '0;
    ifc.commit_intif_complete  = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_pending", 32'(ifc.intif_csrf_pending), 32'h0);
    chk("rst_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);
    chk("rst_ack", 32'(ifc.intif_src_ack), 32'h0);
    chk("rst_err", 32'(ifc.intif_take_err), 32'h0);
    chk("rst_in_service", 32'(ifc.intif_in_service), 32'h0);
    chk("rst_mcause", ifc.intif_commit_mcause_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Level priority: src1 beats src2.
    cyc();
    ifc.csrf_intif_mie         = 3'b111;
    ifc.csrf_intif_mstatus_mie = 1'b1;
    ifc.src_intif_req          = 3'b110;
    cyc(); #1;
    chk("prio_pending", 32'(ifc.intif_csrf_pending), 32'h6);
    chk("prio_claim", 32'(ifc.intif_commit_claim), 32'h2);
    chk("prio_mcause", ifc.intif_commit_mcause_data, 32'h8000_0003);
    chk("prio_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h1);
    ifc.commit_intif_take    = 1'b1;
    ifc.commit_intif_take_id = 3'b010;
    push(3'b010, 1'b0);
    cyc();
    ifc.commit_intif_take    = 1'b0;
    ifc.commit_intif_take_id = '0;
    #1;
    chk("busy_in_service", 32'(ifc.intif_in_service), 32'h1);
    chk("busy_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);
    chk("busy_claim", 32'(ifc.intif_commit_claim), 32'h0);
    chk("busy_id", 32'(ifc.intif_in_service_id), 32'h2);
    cyc(); #1;
    chk("busy_hold_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);
    chk("busy_pending_live", 32'(ifc.intif_csrf_pending), 32'h6);
    ifc.commit_intif_complete = 1'b1;
    cyc();
    ifc.commit_intif_complete = 1'b0;
    #1;
    chk("cmpl_in_service", 32'(ifc.intif_in_service), 32'h0);
    chk("cmpl_claim", 32'(ifc.intif_commit_claim), 32'h2);

    // Edge source keeps its pending bit after the request drops.
    ifc.src_intif_req = 3'b000;
    cyc(); #1;
    chk("edge_latched", 32'(ifc.intif_csrf_pending), 32'h4);
    chk("edge_claim", 32'(ifc.intif_commit_claim), 32'h4);
    chk("edge_mcause", ifc.intif_commit_mcause_data, 32'h8000_0007);
    // Take with a fresh edge in the same cycle: set must win.
    ifc.src_intif_req        = 3'b100;
    ifc.commit_intif_take    = 1'b1;
    ifc.commit_intif_take_id = 3'b100;
    push(3'b100, 1'b0);
    cyc();
    ifc.commit_intif_take    = 1'b0;
    ifc.commit_intif_take_id = '0;
    #1;
    chk("edge_set_wins", 32'(ifc.intif_csrf_pending), 32'h4);
    chk("edge_busy_id", 32'(ifc.intif_in_service_id), 32'h4);
    ifc.commit_intif_complete = 1'b1;
    cyc();
    ifc.commit_intif_complete = 1'b0;
    #1;
    chk("edge_claim2", 32'(ifc.intif_commit_claim), 32'h4);
    // Take without a new edge clears the bit.
    ifc.commit_intif_take    = 1'b1;
    ifc.commit_intif_take_id = 3'b100;
    push(3'b100, 1'b0);
    cyc();
    ifc.commit_intif_take    = 1'b0;
    ifc.commit_intif_take_id = '0;
    #1;
    chk("edge_cleared", 32'(ifc.intif_csrf_pending), 32'h0);
    ifc.commit_intif_complete = 1'b1;
    cyc();
    ifc.commit_intif_complete = 1'b0;
    #1;
    chk("edge_idle_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);

    // Global mask.
    ifc.csrf_intif_mstatus_mie = 1'b0;
    ifc.src_intif_req          = 3'b001;
    cyc(); #1;
    chk("mask_pending", 32'(ifc.intif_csrf_pending), 32'h1);
    chk("mask_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);
    chk("mask_claim", 32'(ifc.intif_commit_claim), 32'h0);
    ifc.csrf_intif_mstatus_mie = 1'b1;
    #1;
    chk("unmask_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h1);
    chk("unmask_claim", 32'(ifc.intif_commit_claim), 32'h1);
    chk("unmask_mcause", ifc.intif_commit_mcause_data, 32'h8000_000B);

    // Bad takes: wrong id, then non-one-hot id.
    ifc.commit_intif_take    = 1'b1;
    ifc.commit_intif_take_id = 3'b010;
    push(3'b000, 1'b1);
    cyc();
    ifc.commit_intif_take_id = 3'b011;
    push(3'b000, 1'b1);
    cyc();
    ifc.commit_intif_take    = 1'b0;
    ifc.commit_intif_take_id = '0;
    #1;
    chk("bad_take_idle", 32'(ifc.intif_in_service), 32'h0);
    chk("bad_take_claim", 32'(ifc.intif_commit_claim), 32'h1);

    // Complete and take together while BUSY on src1: the take is rejected.
    ifc.src_intif_req = 3'b010;
    cyc(); #1;
    chk("src1_claim", 32'(ifc.intif_commit_claim), 32'h2);
    ifc.commit_intif_take    = 1'b1;
    ifc.commit_intif_take_id = 3'b010;
    push(3'b010, 1'b0);
    cyc();
    ifc.commit_intif_take    = 1'b0;
    ifc.commit_intif_take_id = '0;
    ifc.src_intif_req        = 3'b011;
    cyc(); #1;
    chk("busy1_pending", 32'(ifc.intif_csrf_pending), 32'h3);
    chk("busy1_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);
    ifc.commit_intif_complete = 1'b1;
    ifc.commit_intif_take     = 1'b1;
    ifc.commit_intif_take_id  = 3'b001;
    push(3'b000, 1'b1);
    cyc();
    ifc.commit_intif_complete = 1'b0;
    ifc.commit_intif_take     = 1'b0;
    ifc.commit_intif_take_id  = '0;
    #1;
    chk("ct_in_service", 32'(ifc.intif_in_service), 32'h0);
    chk("ct_claim", 32'(ifc.intif_commit_claim), 32'h1);

    // Asynchronous reset while BUSY drops the in-flight ack.
    ifc.commit_intif_take    = 1'b1;
    ifc.commit_intif_take_id = 3'b001;
    cyc();
    ifc.commit_intif_take    = 1'b0;
    ifc.commit_intif_take_id = '0;
    chk("pre_rst_in_service", 32'(ifc.intif_in_service), 32'h1);
    chk("pre_rst_ack", 32'(ifc.intif_src_ack), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_in_service", 32'(ifc.intif_in_service), 32'h0);
    chk("arst_ack", 32'(ifc.intif_src_ack), 32'h0);
    chk("arst_pending", 32'(ifc.intif_csrf_pending), 32'h0);
    chk("arst_has_int", 32'(ifc.intif_commit_has_interrupt), 32'h0);
    chk("arst_err", 32'(ifc.intif_take_err), 32'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
